// File: rtl/count_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_ctrl_pkg                                                       |
// | State type, state encodings and width helper for count_seq_ctrl.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package count_ctrl_pkg;

  localparam logic [1:0] c_enc_idle = 2'd0;
  localparam logic [1:0] c_enc_run  = 2'd1;
  localparam logic [1:0] c_enc_hold = 2'd2;
  localparam logic [1:0] c_enc_done = 2'd3;

  typedef enum logic [1:0] {
    IDLE = c_enc_idle,
    RUN  = c_enc_run,
    HOLD = c_enc_hold,
    DONE = c_enc_done
  } state_t;

  // Register width for a 0..n-1 counter, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_seq_ctrl_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen                                                             |
// | Prescaler for count_seq_ctrl: counts 0..PRESCALE-1 while enabled.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_gen
  import count_ctrl_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic wrap
);

  localparam int            c_pw   = clog2_min1(PRESCALE);
  localparam logic [c_pw-1:0] c_last = c_pw'(PRESCALE - 1);

  logic [c_pw-1:0] r_pre;
  logic            w_last;

  assign w_last = (r_pre == c_last);
  assign wrap   = enable && w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (clear) begin
      r_pre <= '0;
    end else if (enable) begin
      r_pre <= w_last ? '0 : r_pre + c_pw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count_seq_ctrl                                                       |
// | Start/stop/hold sequencer stepping a counter from 0 to a loaded      |
// | limit. Define COUNT_SEQ_CTRL_AUTORELOAD_EN for periodic re-runs.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module count_seq_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_done;
  logic             r_busy;

  logic w_active;
  logic w_pre_en;
  logic w_pre_clr;
  logic w_tick;

  assign w_active = (r_state == RUN) || (r_state == HOLD);
  // The cycle that leaves HOLD is a productive cycle, so each HOLD cycle
  // stretches the run by exactly one cycle.
  assign w_pre_en  = w_active && !stop && !hold;
  assign w_pre_clr = stop || (r_state == IDLE) || (r_state == DONE);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(w_pre_en),
    .clear (w_pre_clr),
    .wrap  (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state <= RUN;
            r_count <= '0;
            r_limit <= load_val;
            r_busy  <= 1'b1;
          end
        end
        RUN, HOLD: begin
          if (stop) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else if (hold) begin
            r_state <= HOLD;
          end else if (w_tick && (r_count == r_limit)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= RUN;
            if (w_tick) begin
              r_count <= r_count + WIDTH'(1);
            end
          end
        end
        DONE: begin
`ifdef COUNT_SEQ_CTRL_AUTORELOAD_EN
          r_count <= '0;
          if (stop) begin
            r_state <= IDLE;
          end else begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
`else
          r_state <= IDLE;
`endif
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign count = r_count;
  assign tick  = w_tick;
  assign done  = r_done;
  assign busy  = r_busy;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_count_seq_ctrl                                                    |
// | Scoreboard bench: expected ticks queued at stimulus, popped on tick. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_count_seq_ctrl;

  typedef struct {
    int cnt;
    int at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start_a = 1'b0, stop_a = 1'b0, hold_a = 1'b0;
  logic [7:0] load_a = 8'd0;
  logic [7:0] count_a;
  logic       tick_a, done_a, busy_a;
  logic [1:0] state_a;

  logic       start_b = 1'b0, stop_b = 1'b0, hold_b = 1'b0;
  logic [7:0] load_b = 8'd0;
  logic [7:0] count_b;
  logic       tick_b, done_b, busy_b;
  logic [1:0] state_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   done_q[$];
  exp_t sb_q[$];
  int   e0;

  count_seq_ctrl #(.WIDTH(8), .PRESCALE(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .hold(hold_a),
    .load_val(load_a), .count(count_a), .tick(tick_a), .done(done_a),
    .busy(busy_a), .state(state_a)
  );

  count_seq_ctrl #(.WIDTH(8), .PRESCALE(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .hold(hold_b),
    .load_val(load_b), .count(count_b), .tick(tick_b), .done(done_b),
    .busy(busy_b), .state(state_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    busy_cnt = 0;
    done_cnt = 0;
    done_q.delete();
  endtask

  // Tick monitor: every observed tick must match the next queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (busy_a) busy_cnt++;
    if (done_a) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
    if (tick_a) begin
      if (sb_q.size() == 0) begin
        chk("tick_extra", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("tick_cnt", {24'd0, count_a}, e.cnt);
        chk("tick_cyc", cyc, e.at);
      end
    end
  end

  initial begin
    #1;
    chk("rst_state", {30'd0, state_a}, 0);
    chk("rst_count", {24'd0, count_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_done", {31'd0, done_a}, 0);
    chk("rst_tick", {31'd0, tick_a}, 0);
    edges(2);
    rst = 1'b1;
    edges(2);

    // start together with stop in IDLE is ignored
    start_a = 1'b1; stop_a = 1'b1;
    edges(2);
    chk("ss_state", {30'd0, state_a}, 0);
    chk("ss_busy", {31'd0, busy_a}, 0);
    start_a = 1'b0; stop_a = 1'b0;
    edges(1);

    // stop with hold during RUN at count 2
    clr_mon();
    load_a = 8'd5; start_a = 1'b1;
    edges(1);
    e0 = cyc; start_a = 1'b0;
    sb_q.push_back('{0, e0 + 3});
    sb_q.push_back('{1, e0 + 7});
    edges(8);
    chk("sp_pre_cnt", {24'd0, count_a}, 2);
    stop_a = 1'b1; hold_a = 1'b1;
    edges(1);
    chk("sp_state", {30'd0, state_a}, 0);
    chk("sp_count", {24'd0, count_a}, 0);
    chk("sp_busy", {31'd0, busy_a}, 0);
    stop_a = 1'b0; hold_a = 1'b0;
    edges(30);
    chk("sp_no_done", done_cnt, 0);
    chk("sp_sb_empty", sb_q.size(), 0);

    // asynchronous reset mid-run at count 5
    clr_mon();
    load_a = 8'd10; start_a = 1'b1;
    edges(1);
    e0 = cyc; start_a = 1'b0;
    for (int k = 1; k <= 5; k++) sb_q.push_back('{k - 1, e0 + 4 * k - 1});
    edges(20);
    chk("rm_pre_cnt", {24'd0, count_a}, 5);
    #2 rst = 1'b0;
    #1;
    chk("rm_count", {24'd0, count_a}, 0);
    chk("rm_state", {30'd0, state_a}, 0);
    chk("rm_busy", {31'd0, busy_a}, 0);
    chk("rm_done", {31'd0, done_a}, 0);
    chk("rm_tick", {31'd0, tick_a}, 0);
    edges(2);
    rst = 1'b1;
    edges(2);
    chk("rm_no_done", done_cnt, 0);
    chk("rm_sb_empty", sb_q.size(), 0);

`ifdef COUNT_SEQ_CTRL_AUTORELOAD_EN
    // periodic runs: limit 1, 8 RUN cycles + 1 DONE cycle per period
    clr_mon();
    load_a = 8'd1; start_a = 1'b1;
    edges(1);
    e0 = cyc; start_a = 1'b0;
    for (int p = 0; p < 3; p++) begin
      sb_q.push_back('{0, e0 + 9 * p + 3});
      sb_q.push_back('{1, e0 + 9 * p + 7});
    end
    edges(26);
    chk("ar_state_done", {30'd0, state_a}, 3);
    stop_a = 1'b1;
    edges(1);
    stop_a = 1'b0;
    chk("ar_stop_state", {30'd0, state_a}, 0);
    chk("ar_stop_count", {24'd0, count_a}, 0);
    chk("ar_done_cnt", done_cnt, 3);
    if (done_q.size() == 3) begin
      chk("ar_gap1", done_q[1] - done_q[0], 9);
      chk("ar_gap2", done_q[2] - done_q[1], 9);
    end else begin
      chk("ar_done_q", done_q.size(), 3);
    end
    chk("ar_sb_empty", sb_q.size(), 0);
`else
    // basic run: limit 3, ticks every 4 cycles
    clr_mon();
    load_a = 8'd3; start_a = 1'b1;
    edges(1);
    e0 = cyc; start_a = 1'b0;
    chk("br_state", {30'd0, state_a}, 1);
    chk("br_count0", {24'd0, count_a}, 0);
    for (int k = 1; k <= 4; k++) sb_q.push_back('{k - 1, e0 + 4 * k - 1});
    edges(22);
    chk("br_done_cnt", done_cnt, 1);
    if (done_q.size() > 0) chk("br_done_at", done_q[0] - e0, 16);
    chk("br_busy_len", busy_cnt, 16);
    chk("br_count_end", {24'd0, count_a}, 3);
    chk("br_state_end", {30'd0, state_a}, 0);
    chk("br_sb_empty", sb_q.size(), 0);

    // hold for 5 cycles at count 1
    clr_mon();
    start_a = 1'b1;
    edges(1);
    e0 = cyc; start_a = 1'b0;
    sb_q.push_back('{0, e0 + 3});
    for (int k = 2; k <= 4; k++) sb_q.push_back('{k - 1, e0 + 4 * k + 4});
    edges(5);
    hold_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk("hd_count", {24'd0, count_a}, 1);
      chk("hd_state", {30'd0, state_a}, 2);
    end
    hold_a = 1'b0;
    edges(16);
    chk("hd_done_cnt", done_cnt, 1);
    if (done_q.size() > 0) chk("hd_done_at", done_q[0] - e0, 21);
    chk("hd_busy_len", busy_cnt, 21);
    chk("hd_sb_empty", sb_q.size(), 0);

    // PRESCALE=1, limit 0: one tick, DONE one edge after RUN entry
    load_b = 8'd0; start_b = 1'b1;
    edges(1);
    start_b = 1'b0;
    chk("b0_state_run", {30'd0, state_b}, 1);
    chk("b0_tick", {31'd0, tick_b}, 1);
    edges(1);
    chk("b0_state_done", {30'd0, state_b}, 3);
    chk("b0_done", {31'd0, done_b}, 1);
    chk("b0_tick_off", {31'd0, tick_b}, 0);
    edges(1);
    chk("b0_state_idle", {30'd0, state_b}, 0);
    chk("b0_done_off", {31'd0, done_b}, 0);

    // PRESCALE=1, limit 255: reaches 255 without wrapping
    load_b = 8'd255; start_b = 1'b1;
    edges(1);
    start_b = 1'b0;
    edges(255);
    chk("bf_count", {24'd0, count_b}, 255);
    chk("bf_state_run", {30'd0, state_b}, 1);
    edges(1);
    chk("bf_state_done", {30'd0, state_b}, 3);
    chk("bf_count_done", {24'd0, count_b}, 255);
    edges(1);
    chk("bf_state_idle", {30'd0, state_b}, 0);
    chk("bf_count_hold", {24'd0, count_b}, 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
